// File: rtl/adder_nbit_seq.sv
// adder_nbit_seq: multi-cycle adder/subtractor, CHUNK bits per clock with a carry register
// Ports: clk, rst (sync, active-high); start, a, b, carry_in, sub, is_signed in;
//        busy, done (one-cycle pulse), sum, carry_out, overflow out (registered, held).
module adder_nbit_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);
    localparam int NUM_CHUNKS = WIDTH / CHUNK;
    localparam int IW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_CHUNKS - 1);

    if (CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_cfg
        $error("adder_nbit_seq: WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, part_q, part_d, sum_q, sum_d;
    logic             c_q, c_d, sub_q, sub_d, sgn_q, sgn_d;
    logic             cout_q, cout_d, ovf_q, ovf_d;
    logic [CHUNK-1:0] a_c, b_c;
    logic [CHUNK:0]   ch;
    logic             cmsb, last;
    int               base;

    always_comb begin
        base    = int'(idx_q) * CHUNK;
        a_c     = a_q[base +: CHUNK];
        b_c     = b_q[base +: CHUNK];
        ch      = {1'b0, a_c} + {1'b0, b_c} + (CHUNK+1)'(c_q);
        // carry into the top bit of the chunk, recovered from its sum bit
        cmsb    = a_c[CHUNK-1] ^ b_c[CHUNK-1] ^ ch[CHUNK-1];
        last    = idx_q == LAST;
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        sub_d   = sub_q;
        sgn_d   = sgn_q;
        part_d  = part_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (state_q == IDLE && start) begin
            // subtract is folded into operand B and the carry so RUN only adds
            state_d = RUN;
            idx_d   = '0;
            a_d     = a;
            b_d     = sub ? ~b : b;
            c_d     = carry_in ^ sub;
            sub_d   = sub;
            sgn_d   = is_signed;
        end else if (state_q == RUN) begin
            part_d[base +: CHUNK] = ch[CHUNK-1:0];
            c_d   = ch[CHUNK];
            idx_d = last ? '0 : idx_q + IW'(1);
            if (last) begin
                state_d = DONE;
                sum_d   = part_d;
                cout_d  = ch[CHUNK];
                ovf_d   = sgn_q ? cmsb ^ ch[CHUNK] : ch[CHUNK] ^ sub_q;
            end
        end else if (state_q != IDLE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            sub_q   <= 1'b0;
            sgn_q   <= 1'b0;
            part_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            sub_q   <= sub_d;
            sgn_q   <= sgn_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_adder_nbit_seq.sv
// tb_adder_nbit_seq: table-driven and scoreboarded bench for adder_nbit_seq (16/4 and 4/4 configurations)
module tb_adder_nbit_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start = 1'b0, cin = 1'b0, sub = 1'b0, sgn = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;

    logic        start4 = 1'b0, cin4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        busy4, done4, cout4, ovf4;
    logic [3:0]  sum4;

    adder_nbit_seq #(.WIDTH(16), .CHUNK(4)) u16 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .carry_in(cin),
        .sub(sub), .is_signed(sgn), .busy(busy16), .done(done16), .sum(sum16),
        .carry_out(cout16), .overflow(ovf16)
    );

    adder_nbit_seq #(.WIDTH(4), .CHUNK(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .carry_in(cin4),
        .sub(1'b0), .is_signed(1'b0), .busy(busy4), .done(done4), .sum(sum4),
        .carry_out(cout4), .overflow(ovf4)
    );

    typedef struct {
        logic [15:0] a, b;
        logic        cin, sub, sgn;
        logic [15:0] s;
        logic        c, o;
    } vec_t;

    typedef struct {
        logic [15:0] s;
        logic        c, o;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic sb, input logic sg);
        logic [15:0] yy;
        logic [16:0] r;
        logic        o;
        yy = sb ? ~y : y;
        r  = {1'b0, x} + {1'b0, yy} + 17'(ci ^ sb);
        o  = sg ? (x[15] == yy[15] && r[15] != x[15]) : r[16] ^ sb;
        return {r[15:0], r[16], o};
    endfunction

    // scoreboard: every done pulse of the 16-bit DUT must match the oldest pending result
    always @(negedge clk) begin
        if (done16) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_sum", 32'(sum16), 32'(e.s));
                check("sb_carry_out", 32'(cout16), 32'(e.c));
                check("sb_overflow", 32'(ovf16), 32'(e.o));
            end
        end
    end

    task automatic run16(input vec_t v);
        int k;
        int nb;
        @(negedge clk);
        a = v.a; b = v.b; cin = v.cin; sub = v.sub; sgn = v.sgn; start = 1'b1;
        exp_q.push_back('{v.s, v.c, v.o});
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
        cin = 1'($urandom); sub = 1'($urandom); sgn = 1'($urandom);
        k = 0;
        nb = busy16 ? 1 : 0;
        while (!done16 && k < 20) begin
            @(posedge clk); #1;
            k++;
            if (busy16) nb++;
        end
        check("latency_edges", 32'(k), 32'd4);
        check("busy_cycles", 32'(nb), 32'd5);
        @(posedge clk); #1;
        check("done_single_pulse", 32'(done16), 32'd0);
        check("busy_after_done", 32'(busy16), 32'd0);
    endtask

    vec_t vt[10];

    initial begin
        vt[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[2] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
        vt[4] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b1};
        vt[5] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vt[6] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, 16'hFFFD, 1'b0, 1'b1};
        vt[7] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vt[8] = '{16'h0FFF, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h1001, 1'b0, 1'b0};
        vt[9] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy16), 32'd0);
        check("rst_done", 32'(done16), 32'd0);
        check("rst_sum", 32'(sum16), 32'd0);
        check("rst_carry_out", 32'(cout16), 32'd0);
        check("rst_overflow", 32'(ovf16), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run16(vt[i]);

        for (int i = 0; i < 8; i++) begin
            vec_t v;
            logic [17:0] r;
            v.a = 16'($urandom); v.b = 16'($urandom);
            v.cin = 1'($urandom); v.sub = 1'($urandom); v.sgn = 1'($urandom);
            r = model(v.a, v.b, v.cin, v.sub, v.sgn);
            v.s = r[17:2]; v.c = r[1]; v.o = r[0];
            run16(v);
        end

        // start held high: back-to-back acceptance every NUM_CHUNKS+2 cycles
        begin
            int d0, d1, nd;
            d0 = -1; d1 = -1; nd = 0;
            @(negedge clk);
            a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; sgn = 1'b0; start = 1'b1;
            exp_q.push_back('{16'h5555, 1'b0, 1'b0});
            exp_q.push_back('{16'h5555, 1'b0, 1'b0});
            for (int i = 0; i < 40 && nd < 2; i++) begin
                @(posedge clk); #1;
                if (done16) begin
                    if (nd == 0) d0 = i; else d1 = i;
                    nd++;
                end
            end
            start = 1'b0;
            check("held_done_count", 32'(nd), 32'd2);
            check("held_first_done", 32'(d0), 32'd4);
            check("held_period", 32'(d1 - d0), 32'd6);
        end

        // reset on the third RUN edge aborts with no done pulse and zeroed outputs
        begin
            int nd;
            repeat (3) @(posedge clk);
            @(negedge clk);
            a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; sgn = 1'b0; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check("abort_busy", 32'(busy16), 32'd0);
            check("abort_done", 32'(done16), 32'd0);
            check("abort_sum", 32'(sum16), 32'd0);
            check("abort_carry_out", 32'(cout16), 32'd0);
            check("abort_overflow", 32'(ovf16), 32'd0);
            nd = 0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                if (done16) nd++;
            end
            check("abort_no_done", 32'(nd), 32'd0);
        end

        run16(vt[0]);

        // exhaustive sweep of the single-chunk configuration
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            logic [4:0] r;
            int k;
            v = 9'(i);
            @(negedge clk);
            a4 = v[3:0]; b4 = v[7:4]; cin4 = v[8]; start4 = 1'b1;
            r = {1'b0, v[3:0]} + {1'b0, v[7:4]} + 5'(v[8]);
            @(posedge clk); #1;
            start4 = 1'b0;
            k = 0;
            while (!done4 && k < 10) begin
                @(posedge clk); #1;
                k++;
            end
            check("w4_latency", 32'(k), 32'd1);
            check("w4_sum", 32'(sum4), 32'(r[3:0]));
            check("w4_carry_out", 32'(cout4), 32'(r[4]));
            check("w4_overflow", 32'(ovf4), 32'(r[4]));
            @(posedge clk); #1;
        end

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
